// File: rtl/otter_lsu_pkg.sv
// Shared types, funct3 encodings and the request legality check for the OTTER load/store unit.
package otter_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    // Legal means exactly one strobe, a funct3 valid for that direction, and natural alignment.
    function automatic logic req_legal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = rd ^ wr;
        if (rd)
            ok = ok && (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        else
            ok = ok && (f3 == F3_B || f3 == F3_H || f3 == F3_W);
        if (f3[1:0] == 2'b01 && off[0])
            ok = 1'b0;
        if (f3[1:0] == 2'b10 && off != 2'b00)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/otter_lsu_align.sv
// Byte-lane steering: store data replication with byte enables, and load lane extraction with extension.
module otter_lsu_align
    import otter_lsu_pkg::*;
(
    input  logic [2:0]      func3,
    input  logic [1:0]      offset,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata,
    output logic [31:0]     store_data,
    output logic [BE_W-1:0] store_be,
    output logic [31:0]     load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        store_data = wdata;
        store_be   = 4'b1111;
        case (func3[1:0])
            2'b00: begin
                store_data = {4{wdata[7:0]}};
                store_be   = 4'b0001 << offset;
            end
            2'b01: begin
                store_data = {2{wdata[15:0]}};
                store_be   = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = wdata;
                store_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];

        case (func3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'd0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'd0, lane_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit: IDLE/REQ/DONE bus sequencer with BUSY stall and ERR pulse.
// Define OTTER_LSU_TIMEOUT_EN to abort a REQ after TIMEOUT_CYC cycles without BUS_ACK.
module otter_lsu
    import otter_lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MEM_READ,
    input  logic              MEM_WRITE,
    input  logic [2:0]        FUNC3,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] LOAD_DATA,
    output logic              LOAD_VALID,
    output logic              BUSY,
    output logic              ERR,
    output logic              BUS_REQ,
    output logic              BUS_WE,
    output logic [ADDR_W-1:0] BUS_ADDR,
    output logic [DATA_W-1:0] BUS_WDATA,
    output logic [BE_W-1:0]   BUS_BE,
    input  logic              BUS_ACK,
    input  logic [DATA_W-1:0] BUS_RDATA
);

    // Bus handshake: BUS_REQ rises in REQ and holds with stable address/data/BE until the
    // cycle BUS_ACK is seen high; that cycle completes the transfer and BUS_RDATA is valid.

    lsu_state_t state, next_state;

    logic              legal, accept, reject, timeout;
    logic              we_q;
    logic [2:0]        func3_q;
    logic [1:0]        offset_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] load_q;
    logic              err_q;

    logic [2:0]        sel_func3;
    logic [1:0]        sel_offset;
    logic [DATA_W-1:0] st_data, ld_data;
    logic [BE_W-1:0]   st_be;

    assign legal  = req_legal(MEM_READ, MEM_WRITE, FUNC3, ADDR[1:0]);
    assign accept = (state == IDLE) && legal && !RST;
    assign reject = (state == IDLE) && (MEM_READ || MEM_WRITE) && !legal && !RST;

    // One align instance serves both paths: live request fields in IDLE, registered ones in REQ.
    assign sel_func3  = (state == IDLE) ? FUNC3 : func3_q;
    assign sel_offset = (state == IDLE) ? ADDR[1:0] : offset_q;

    otter_lsu_align u_align (
        .func3      (sel_func3),
        .offset     (sel_offset),
        .wdata      (WDATA),
        .rdata      (BUS_RDATA),
        .store_data (st_data),
        .store_be   (st_be),
        .load_data  (ld_data)
    );

`ifdef OTTER_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (state == REQ) && !BUS_ACK && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (RST || state != REQ)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        BUSY       = 1'b0;
        BUS_REQ    = 1'b0;
        LOAD_VALID = 1'b0;
        case (state)
            IDLE: begin
                BUSY = accept;
                if (accept)
                    next_state = REQ;
            end
            REQ: begin
                BUSY    = 1'b1;
                BUS_REQ = 1'b1;
                if (BUS_ACK)
                    next_state = DONE;
                else if (timeout)
                    next_state = IDLE;
            end
            DONE: begin
                LOAD_VALID = !we_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q     <= 1'b0;
            func3_q  <= 3'd0;
            offset_q <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            load_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= reject || timeout;
            if (accept) begin
                we_q     <= MEM_WRITE;
                func3_q  <= FUNC3;
                offset_q <= ADDR[1:0];
                addr_q   <= {ADDR[ADDR_W-1:2], 2'b00};
                wdata_q  <= st_data;
                be_q     <= MEM_WRITE ? st_be : {BE_W{1'b1}};
            end
            if (state == REQ && BUS_ACK && !we_q)
                load_q <= ld_data;
        end
    end

    assign BUS_WE    = BUS_REQ && we_q;
    assign BUS_ADDR  = BUS_REQ ? addr_q  : '0;
    assign BUS_WDATA = BUS_REQ ? wdata_q : '0;
    assign BUS_BE    = BUS_REQ ? be_q    : '0;
    assign LOAD_DATA = load_q;
    assign ERR       = err_q;

endmodule

// File: doc/otter_lsu.md
Name: otter_lsu

Overview:
- Load/store unit sitting directly downstream of the CPU's memory-stage pipeline register.
- Consumes the memory-stage address, store data, funct3 and read/write strobes.
- Drives a word-addressed valid/ack data bus with byte enables, and returns sign/zero-extended load data to writeback.
- Asserts BUSY so the hazard logic freezes the pipeline until the bus transaction completes.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, bus data width; fixed at 32 (4 byte lanes), other values unsupported
- TIMEOUT_CYC, 255, cycles in REQ without BUS_ACK before abort (used only with LSU_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- MEM_READ  in  1  load request from memory stage
- MEM_WRITE  in  1  store request from memory stage
- FUNC3  in  3  RV32I load/store funct3
- ADDR  in  ADDR_W  byte address (ALU result)
- WDATA  in  DATA_W  store data (rs2, forwarded)
- LOAD_DATA  out  DATA_W  extended load result to writeback
- LOAD_VALID  out  1  one-cycle pulse; LOAD_DATA is new
- BUSY  out  1  stall request to hazard unit
- ERR  out  1  one-cycle pulse: misaligned, illegal funct3, read+write conflict, or timeout
- BUS_REQ  out  1  bus request, held until BUS_ACK
- BUS_WE  out  1  1 = write
- BUS_ADDR  out  ADDR_W  word-aligned address (ADDR[1:0] forced to 0)
- BUS_WDATA  out  DATA_W  lane-replicated store data
- BUS_BE  out  4  byte enables (all 1 for reads)
- BUS_ACK  in  1  transaction complete; read data valid this cycle
- BUS_RDATA  in  DATA_W  read data

Behaviour:
- Reset (on the CLK edge with RST=1): state IDLE; all outputs 0. LOAD_DATA is also cleared. Reset mid-transaction abandons it; BUS_REQ is low the following cycle; no LOAD_VALID or ERR is produced.
- States:
  - IDLE: waits for a request.
  - REQ: BUS_REQ=1 and bus outputs stable.
  - DONE: one cycle; LOAD_VALID pulses for loads.
- IDLE, accept condition: MEM_READ^MEM_WRITE, legal FUNC3, aligned address.
  - Request fields are registered; next state is REQ.
  - BUSY is driven combinationally high in the same cycle, so the pipeline holds the request.
- IDLE, illegal request → ERR pulses the next cycle; no bus activity, BUSY stays 0, state stays IDLE. Illegal means any of:
  - MEM_READ and MEM_WRITE both high;
  - FUNC3 not in {000, 001, 010, 100, 101} for loads or {000, 001, 010} for stores;
  - half access with ADDR[0]=1;
  - word access with ADDR[1:0]≠0.
- REQ:
  - BUSY=1.
  - On BUS_ACK, BUS_RDATA is captured (loads) and the next state is DONE.
  - BUS_ACK in the first REQ cycle is legal.
  - BUS_ACK while IDLE or DONE is ignored.
- DONE:
  - BUSY=0 and BUS_REQ=0.
  - Loads: LOAD_VALID=1 with the extended LOAD_DATA.
  - Next state is IDLE. A new request is not accepted in DONE; it is accepted the next cycle.
  - Minimum op latency: accept cycle N, BUS_REQ at N+1, earliest ACK at N+1, LOAD_VALID at N+2.
- Store lane steering:
  - SB: byte replicated ×4; BE = 1<<ADDR[1:0].
  - SH: half replicated ×2; BE = 0011 (ADDR[1]=0) or 1100.
  - SW: data unchanged; BE = 1111.
- Load extraction:
  - LB/LBU: byte at lane ADDR[1:0].
  - LH/LHU: half at ADDR[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW: unchanged.
- LOAD_DATA holds its value until the next completed load. Stores never change it.

Optional Feature:
- OTTER_LSU_TIMEOUT_EN defined:
  - An 8-bit-minimum counter (width to hold TIMEOUT_CYC) counts REQ cycles.
  - If TIMEOUT_CYC cycles elapse without BUS_ACK: BUS_REQ drops, ERR pulses one cycle, state returns to IDLE, BUSY falls, no LOAD_VALID.
  - The counter clears on entry to REQ.
- Undefined: no counter; REQ waits indefinitely for BUS_ACK.

Decomposition:
- Package otter_lsu_pkg:
  - state enum lsu_state_t {IDLE, REQ, DONE};
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - BE width localparam.
- Sub-module otter_lsu_align: purely combinational. Store lane replication plus BE generation, and load lane extraction plus extension; shared by both paths via FUNC3/offset inputs.

Test Plan:
- SW ADDR=0x100, WDATA=0xDEADBEEF, ACK after 3 cycles → BUS_ADDR=0x100, BE=1111, BUS_WE=1, BUSY high 4 cycles, no LOAD_VALID.
- LB ADDR=0x203, BUS_RDATA=0x80_11_22_33 → LOAD_DATA=0xFFFFFF80; LBU same → 0x00000080; LOAD_VALID one cycle after ACK.
- SH ADDR=0x302, WDATA=0x0000ABCD → BUS_WDATA=0xABCDABCD, BE=1100, BUS_ADDR=0x300.
- LW ADDR=0x101 → ERR pulse next cycle, BUS_REQ never asserted, BUSY=0; MEM_READ=MEM_WRITE=1 → ERR, no bus activity.
- RST asserted in REQ before ACK → next cycle BUS_REQ=0, all outputs 0; a late ACK produces no LOAD_VALID.
- OTTER_LSU_TIMEOUT_EN, TIMEOUT_CYC=4, ACK never asserted → BUS_REQ high exactly 4 cycles, then ERR pulse, BUSY=0.
